// File: rtl/linear_engine_arbiter_if.sv
// Requester/engine bus of the linear engine arbiter.
//   req         requester -> arbiter  level request per requester
//   grant       arbiter -> requester  one-hot winner, held for the transaction
//   grant_idx   arbiter -> mux        binary index of the winner
//   ack         arbiter -> requester  one-cycle completion pulse to the winner
//   busy        arbiter -> system     high while a transaction is in flight
//   timeout_err arbiter -> system     watchdog abort pulse (with ack)
//   eng_enable  arbiter -> engine     engine run enable
//   eng_done    engine -> arbiter     engine completion
// master: requester/engine side; slave: the arbiter.
interface linear_engine_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] ack;
  logic               busy;
  logic               timeout_err;
  logic               eng_enable;
  logic               eng_done;

  modport master (
    output req, eng_done,
    input  grant, grant_idx, ack, busy, timeout_err, eng_enable
  );

  modport slave (
    input  req, eng_done,
    output grant, grant_idx, ack, busy, timeout_err, eng_enable
  );
endinterface

// File: rtl/linear_engine_arbiter.sv
// Round-robin arbiter sharing one linear/mmmul engine among NUM_REQ requesters.
// A winner is granted for a whole transaction (enable held until the engine
// reports done), receives a one-cycle ack, and the engine then sees its enable
// low for at least two cycles before the next transaction.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    linear_engine_arbiter_if.slave (req/grant/grant_idx/ack/busy/
//          timeout_err/eng_enable/eng_done)
//
// Build option: define ARB_TIMEOUT_EN to add a RUN watchdog of TIMEOUT cycles
// that aborts a hung transaction with ack + timeout_err. Without it
// timeout_err is tied low and RUN waits for eng_done indefinitely.
//
// state | meaning
// IDLE  | no transaction, arbitrate on any request
// RUN   | engine enabled for the registered winner
// ACK   | one-cycle ack to the winner, engine disabled
module linear_engine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 256
) (
  input logic                   clk,
  input logic                   rst_n,
  linear_engine_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("linear_engine_arbiter: NUM_REQ must be 2..16");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("linear_engine_arbiter: TIMEOUT must be 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               eng_enable_q, eng_enable_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [IDX_W-1:0]   last_winner_q, last_winner_d;
  // last_winner resets to 0 but the very first search must start at 0, not 1;
  // won_any distinguishes "nobody has won yet" from "requester 0 won last".
  logic               won_any_q, won_any_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  // Round-robin pick
  logic [IDX_W-1:0]   search_start;
  logic [IDX_W:0]     cand_sum;
  logic [IDX_W-1:0]   cand_idx;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;

  always_comb begin
    search_start = '0;
    cand_sum     = '0;
    cand_idx     = '0;
    pick_found   = 1'b0;
    pick_idx     = '0;

    if (won_any_q) begin
      if (last_winner_q == IDX_W'(NUM_REQ - 1)) begin
        search_start = '0;
      end else begin
        search_start = last_winner_q + 1'b1;
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, search_start} + (IDX_W + 1)'(i);
      if (cand_sum >= (IDX_W + 1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand_idx = cand_sum[IDX_W-1:0];
      if (!pick_found && bus.req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state / output logic
  logic run_end;
  logic wd_hit;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    eng_enable_d  = eng_enable_q;
    ack_d         = '0;
    last_winner_d = last_winner_q;
    won_any_d     = won_any_q;
    run_end       = 1'b0;
    wd_hit        = 1'b0;
`ifdef ARB_TIMEOUT_EN
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d      = S_RUN;
          grant_d      = NUM_REQ'(1) << pick_idx;
          grant_idx_d  = pick_idx;
          eng_enable_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          wd_cnt_d     = '0;
`endif
        end
      end

      S_RUN: begin
`ifdef ARB_TIMEOUT_EN
        // This edge closes RUN cycle wd_cnt_q+1; TIMEOUT cycles without done aborts.
        wd_hit = !bus.eng_done && (wd_cnt_q == WD_LAST);
`endif
        run_end = bus.eng_done || wd_hit;
        if (run_end) begin
          state_d       = S_ACK;
          eng_enable_d  = 1'b0;
          ack_d         = grant_q;
          last_winner_d = grant_idx_q;
          won_any_d     = 1'b1;
`ifdef ARB_TIMEOUT_EN
          timeout_err_d = wd_hit;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        end
      end

      S_ACK: begin
        state_d     = S_IDLE;
        grant_d     = '0;
        grant_idx_d = '0;
      end

      default: begin
        state_d      = S_IDLE;
        grant_d      = '0;
        grant_idx_d  = '0;
        eng_enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      eng_enable_q  <= 1'b0;
      ack_q         <= '0;
      last_winner_q <= '0;
      won_any_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      eng_enable_q  <= eng_enable_d;
      ack_q         <= ack_d;
      last_winner_q <= last_winner_d;
      won_any_q     <= won_any_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.grant      = grant_q;
  assign bus.grant_idx  = grant_idx_q;
  assign bus.eng_enable = eng_enable_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_linear_engine_arbiter.sv
module tb_linear_engine_arbiter;
  localparam int N = 4;
`ifdef ARB_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 256;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  linear_engine_arbiter_if #(.NUM_REQ(N)) bus ();

  linear_engine_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] ix,
                         input logic e, input logic [3:0] a, input logic b, input logic t);
    chk({tag, ".grant"},       32'(bus.grant),       32'(g));
    chk({tag, ".grant_idx"},   32'(bus.grant_idx),   32'(ix));
    chk({tag, ".eng_enable"},  32'(bus.eng_enable),  32'(e));
    chk({tag, ".ack"},         32'(bus.ack),         32'(a));
    chk({tag, ".busy"},        32'(bus.busy),        32'(b));
    chk({tag, ".timeout_err"}, 32'(bus.timeout_err), 32'(t));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.req = '0;
    bus.eng_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all({tag, ".rst"}, 4'b0, 2'd0, 1'b0, 4'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Directed table: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       en;
    logic [3:0] ack;
    logic       busy;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input logic d, input logic [3:0] g,
                              input logic [1:0] ix, input logic e, input logic [3:0] a,
                              input logic b);
    vec_t v;
    v.req = r; v.done = d; v.grant = g; v.idx = ix; v.en = e; v.ack = a; v.busy = b;
    return v;
  endfunction

  vec_t tbl[14];

  // Transaction-level reference: who owns the engine, and whether we're in the ack cycle.
  int m_owner;
  int m_last;
  int m_runcnt;
  bit m_first;
  bit m_in_ack;
  bit m_to;

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_runcnt = 0; m_first = 1'b1; m_in_ack = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int base;
    int c;
    if (m_in_ack) begin
      m_in_ack = 1'b0;
      m_owner  = -1;
      m_to     = 1'b0;
    end else if (m_owner < 0) begin
      if (r != 4'b0) begin
        base = m_first ? 0 : (m_last + 1) % N;
        for (int k = 0; k < N; k++) begin
          c = (base + k) % N;
          if (m_owner < 0 && r[c]) m_owner = c;
        end
        m_runcnt = 0;
      end
    end else begin
      m_runcnt++;
      if (d || (TO_EN && m_runcnt >= TO)) begin
        m_in_ack = 1'b1;
        m_to     = !d;
        m_last   = m_owner;
        m_first  = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    int low;
    int hi;
    int spurious;
    int held;
    logic [3:0] nr;
    logic       nd;
    logic [3:0] eg;
    logic [3:0] ea;

    bus.req = '0;
    bus.eng_done = 1'b0;

    tbl[0]  = mk(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1);
    tbl[1]  = mk(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1);
    tbl[2]  = mk(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b1);
    tbl[3]  = mk(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0010, 1'b1);
    tbl[4]  = mk(4'b0010, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tbl[5]  = mk(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tbl[6]  = mk(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tbl[7]  = mk(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b1);
    tbl[8]  = mk(4'b1001, 1'b1, 4'b1000, 2'd3, 1'b0, 4'b1000, 1'b1);
    tbl[9]  = mk(4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tbl[10] = mk(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000, 1'b1);
    tbl[11] = mk(4'b1001, 1'b1, 4'b0001, 2'd0, 1'b0, 4'b0001, 1'b1);
    tbl[12] = mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
    tbl[13] = mk(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);

    // Directed table: single requester, done in IDLE/ACK ignored, round-robin rotation.
    do_reset("tbl");
    for (int i = 0; i < 14; i++) begin
      bus.req = tbl[i].req;
      bus.eng_done = tbl[i].done;
      tick();
      chk_all($sformatf("tbl%0d", i), tbl[i].grant, tbl[i].idx, tbl[i].en,
              tbl[i].ack, tbl[i].busy, 1'b0);
    end

    // All requesting: order 0,1,2,3,0 with at least two idle-enable cycles between.
    do_reset("rr");
    bus.req = 4'b1111;
    low = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!bus.eng_enable && n < 20) begin
        tick();
        n++;
        if (!bus.eng_enable) low++;
      end
      chk($sformatf("rr%0d.enable_seen", k), 32'(bus.eng_enable), 32'd1);
      chk($sformatf("rr%0d.order", k), 32'(bus.grant_idx), 32'(k % N));
      chk($sformatf("rr%0d.grant", k), 32'(bus.grant), 32'(4'b0001 << (k % N)));
      if (k > 0) chk($sformatf("rr%0d.gap_ge2", k), 32'(low >= 2), 32'd1);
      tick();
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      chk($sformatf("rr%0d.ack", k), 32'(bus.ack), 32'(4'b0001 << (k % N)));
      chk($sformatf("rr%0d.en_off", k), 32'(bus.eng_enable), 32'd0);
      low = 1;
    end

    // Requester drops req mid-RUN: transaction still completes, no re-grant.
    do_reset("drop");
    bus.req = 4'b0100;
    tick();
    chk("drop.grant", 32'(bus.grant), 32'(4'b0100));
    bus.req = 4'b0000;
    tick();
    chk("drop.en_held", 32'(bus.eng_enable), 32'd1);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("drop.ack", 32'(bus.ack), 32'(4'b0100));
    spurious = 0;
    repeat (10) begin
      tick();
      if (bus.grant != 4'b0 || bus.ack != 4'b0 || bus.eng_enable) spurious++;
    end
    chk("drop.no_spurious", 32'(spurious), 32'd0);

    // Reset mid-RUN drops outputs asynchronously, then requester 3 is granted again.
    do_reset("mrst");
    bus.req = 4'b1000;
    tick();
    chk("mrst.grant", 32'(bus.grant), 32'(4'b1000));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.en_async", 32'(bus.eng_enable), 32'd0);
    chk("mrst.grant_async", 32'(bus.grant), 32'd0);
    chk("mrst.ack_async", 32'(bus.ack), 32'd0);
    chk("mrst.busy_async", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_all("mrst.regrant", 4'b1000, 2'd3, 1'b1, 4'b0000, 1'b1, 1'b0);
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    bus.req = 4'b0000;
    chk("mrst.ack", 32'(bus.ack), 32'(4'b1000));
    tick();

    // Engine never finishes.
    do_reset("wd");
    bus.req = 4'b0011;
    tick();
    chk("wd.grant", 32'(bus.grant), 32'(4'b0001));
`ifdef ARB_TIMEOUT_EN
    hi = 1;
    while (bus.eng_enable && hi < 50) begin
      tick();
      if (bus.eng_enable) hi++;
    end
    chk("wd.run_cycles", 32'(hi), 32'(TO));
    chk("wd.ack", 32'(bus.ack), 32'(4'b0001));
    chk("wd.timeout_err", 32'(bus.timeout_err), 32'd1);
    tick();
    chk("wd.err_pulse", 32'(bus.timeout_err), 32'd0);
    chk("wd.ack_pulse", 32'(bus.ack), 32'd0);
    tick();
    chk("wd.next_grant", 32'(bus.grant), 32'(4'b0010));
`else
    hi = 0;
    held = 0;
    repeat (1100) begin
      tick();
      if (bus.grant == 4'b0001 && bus.eng_enable && bus.ack == 4'b0 && !bus.timeout_err) held++;
    end
    chk("wd.held", 32'(held), 32'd1100);
`endif

    // Random traffic against the transaction-level model.
    do_reset("rand");
    model_reset();
    nr = 4'b0;
    nd = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) nr = 4'($urandom_range(0, 15));
      nd = ($urandom_range(0, 3) == 0);
      bus.req = nr;
      bus.eng_done = nd;
      @(posedge clk);
      model_step(nr, nd);
      #1;
      eg = (m_owner >= 0) ? 4'(4'b0001 << m_owner) : 4'b0;
      ea = m_in_ack ? eg : 4'b0;
      chk_all($sformatf("rand%0d", cyc), eg, (m_owner >= 0) ? 2'(m_owner) : 2'd0,
              (m_owner >= 0) && !m_in_ack, ea, (m_owner >= 0), m_in_ack && m_to);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
